spi_cmd_handler: RTL and testbench
==================================

SPI_CMD_HANDLER -- requirements
Module: spi_cmd_handler

Interface
REQ-001 SHALL have parameter STATUS_ID, default 4'h1, meaning the version nibble returned in the status byte.
REQ-002 SHALL have port clk  in  1  system clock; the block uses this one clock only.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mosi_data  in  8  last received SPI byte, valid while next_byte_ready is high.
REQ-005 SHALL have port next_byte_ready  in  1  one-clk pulse per completed SPI byte.
REQ-006 SHALL have port new_transfer  in  1  one-clk pulse at the first SCK edge after nCS falls.
REQ-007 SHALL have port miso_data  out  8  byte the SPI stage loads at the end of the current byte, so it is shifted out during the following byte.
REQ-008 SHALL have port reg_addr  out  7  register address.
REQ-009 SHALL have port reg_wdata  out  8  register write data.
REQ-010 SHALL have port reg_we  out  1  one-clk register write strobe.
REQ-011 SHALL have port reg_rdata  in  8  combinational read data for reg_addr.
REQ-012 SHALL have port rx_data  in  8  stream FIFO head.
REQ-013 SHALL have port rx_valid  in  1  FIFO non-empty.
REQ-014 SHALL have port rx_pop  out  1  one-clk FIFO pop.

Function
REQ-015 SHALL implement the FSM states IDLE, CMD, WRITE and READ.
REQ-016 SHALL, in any state, on new_transfer go to CMD and set miso_data = {rx_valid,3'b000,STATUS_ID}, so the status byte is shifted out in data byte 1.
REQ-017 SHALL, in CMD, on next_byte_ready decode the command byte: bit7=1 selects READ, bit7=0 selects WRITE, and reg_addr = mosi_data[6:0].
REQ-018 SHALL, on entering READ, in the decode cycle +1 set miso_data = read value of reg_addr, which is shifted out during data byte 2.
REQ-019 SHALL, in READ, on each next_byte_ready advance reg_addr by +1 (wrap 0x7E->0x00) and, one clk later, load miso_data with the new read value.
REQ-020 SHALL, in READ, on each next_byte_ready ignore mosi_data.
REQ-021 SHALL treat reg_addr 0x7F as the stream address: no increment; read value = rx_data if rx_valid else 8'h00.
REQ-022 SHALL pulse rx_pop for one clk at each stream load where rx_valid=1, and never pulse it when rx_valid=0.
REQ-023 SHALL, in WRITE, on each next_byte_ready drive reg_wdata = mosi_data and pulse reg_we for one clk at the current reg_addr.
REQ-024 SHALL, in WRITE, advance reg_addr by +1 after each write, with the same wrap and 0x7F rules as READ.
REQ-025 SHALL, in WRITE, hold miso_data at 8'h00.
REQ-026 SHALL, when new_transfer and next_byte_ready coincide, apply new_transfer first and then decode mosi_data as the command in the same cycle.
REQ-027 SHALL, on a new_transfer mid-READ or mid-WRITE, abort the transfer with no further reg_we or rx_pop from the old transfer.
REQ-028 SHALL ignore next_byte_ready in IDLE.
REQ-029 SHALL have reg_we and rx_pop never high in the same cycle.
REQ-030 SHALL perform address arithmetic in 7 bits modulo 0x7F for register space.

Reset
REQ-031 SHALL, while reset is high, drive state=IDLE, miso_data=8'h00, reg_addr=7'h00, reg_wdata=8'h00, reg_we=0 and rx_pop=0.
REQ-032 SHALL, on reset mid-transfer, discard the transfer, and the next transfer SHALL start only on a new_transfer pulse.

Structure
REQ-033 SHALL place the state enum, STREAM_ADDR=7'h7F, CMD_READ_BIT=7 and the status-byte layout in the shared package spi_cmd_pkg.
REQ-034 SHALL be a single module without sub-modules, because the address/stream mux is too small to warrant one.

Verification
REQ-035 SHALL cover status: new_transfer with rx_valid=1 and STATUS_ID=1 -> miso_data=8'h81 within 1 clk.
REQ-036 SHALL cover register read: command 8'h85, then 3 bytes, with reg_rdata=addr+8'h10 -> miso_data sequence 8'h15, 8'h16, 8'h17 and reg_addr 5->6->7.
REQ-037 SHALL cover register write: command 8'h7E, then data 8'hAA, 8'hBB -> reg_we at addr 0x7E with 8'hAA, then at 0x00 with 8'hBB (wrap).
REQ-038 SHALL cover stream read: command 8'hFF with a FIFO holding 2 entries and 4 bytes clocked -> 2 rx_pop pulses, miso_data = entry0, entry1, 8'h00, 8'h00, and reg_addr stays 0x7F.
REQ-039 SHALL cover abort: new_transfer during WRITE after 1 data byte -> exactly 1 reg_we, state=CMD, and the next byte is decoded as a command.
REQ-040 SHALL cover reset: asynchronous reset asserted mid-READ -> all outputs at reset values immediately, and a following next_byte_ready without new_transfer is ignored.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command handler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Address 0x7F is not a register: it maps onto the RX stream FIFO head.
    localparam logic [6:0] STREAM_ADDR  = 7'h7F;
    // Last real register before the address wraps back to 0x00.
    localparam logic [6:0] ADDR_LAST    = 7'h7E;
    // Command byte bit that selects a read (1) or a write (0).
    localparam int         CMD_READ_BIT = 7;

    // Status byte returned during the first data byte of every transfer.
    typedef struct packed {
        logic       fifo_valid;
        logic [2:0] rsvd;
        logic [3:0] id;
    } status_t;

    function automatic logic [7:0] status_byte(input logic fifo_valid, input logic [3:0] id);
        status_t s;
        s.fifo_valid = fifo_valid;
        s.rsvd       = 3'b000;
        s.id         = id;
        return s;
    endfunction

    // Register space is 0x00..0x7E and wraps; the stream address never moves.
    function automatic logic [6:0] next_addr(input logic [6:0] addr);
        if (addr == STREAM_ADDR) begin
            return STREAM_ADDR;
        end else if (addr == ADDR_LAST) begin
            return 7'h00;
        end else begin
            return addr + 7'd1;
        end
    endfunction

endpackage

// File: rtl/spi_cmd_handler.sv
// Decodes SPI command bytes into register reads/writes and RX-stream reads.
// Latency: reg write strobe 1 clk after a byte; read data loaded 1 clk after address settles.
// Backpressure: none; the SPI byte cadence (>= 8 SCK per byte) leaves the FIFO pop time to land.
module spi_cmd_handler
    import spi_cmd_pkg::*;
#(
    parameter logic [3:0] STATUS_ID = 4'h1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] mosi_data,
    input  logic       next_byte_ready,
    input  logic       new_transfer,
    output logic [7:0] miso_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_pop
);

    state_t     state;
    logic       load_pend;   // a read value is due into miso_data this cycle
    logic       is_stream;
    logic [7:0] rd_val;
    logic       decode_now;
    logic       cmd_is_read;

    // Read mux between register file and stream FIFO, plus command decode qualifiers.
    always_comb begin
        is_stream   = (reg_addr == STREAM_ADDR);
        rd_val      = reg_rdata;
        if (is_stream) begin
            rd_val = rx_valid ? rx_data : 8'h00;
        end
        // A byte arriving together with new_transfer is the command of the new transfer.
        decode_now  = next_byte_ready && (new_transfer || (state == ST_CMD));
        cmd_is_read = mosi_data[CMD_READ_BIT];
    end

    // Transfer FSM with registered outputs; new_transfer overrides everything, decode is applied last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            miso_data <= 8'h00;
            reg_addr  <= 7'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            rx_pop    <= 1'b0;
            load_pend <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            rx_pop    <= 1'b0;
            load_pend <= 1'b0;

            if (new_transfer) begin
                // Dropping load_pend and the strobes here aborts any old transfer cleanly.
                state     <= ST_CMD;
                miso_data <= status_byte(rx_valid, STATUS_ID);
            end else begin
                case (state)
                    ST_READ: begin
                        if (load_pend) begin
                            miso_data <= rd_val;
                            rx_pop    <= is_stream && rx_valid;
                        end
                        if (next_byte_ready) begin
                            reg_addr  <= next_addr(reg_addr);
                            load_pend <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        // Address moves only after the strobe cycle so reg_we sees a stable address.
                        if (reg_we) begin
                            reg_addr <= next_addr(reg_addr);
                        end
                        if (next_byte_ready) begin
                            reg_wdata <= mosi_data;
                            reg_we    <= 1'b1;
                            miso_data <= 8'h00;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (decode_now) begin
                reg_addr  <= mosi_data[6:0];
                load_pend <= cmd_is_read;
                state     <= cmd_is_read ? ST_READ : ST_WRITE;
                // Keep a freshly loaded status byte; otherwise writes return zeros.
                if (!cmd_is_read && !new_transfer) begin
                    miso_data <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_handler.sv
// Self-checking bench for spi_cmd_handler with a register-file and FIFO model.
// Latency: checks outputs #1 after the edge that should update them.
// Backpressure: FIFO model pops on rx_pop at the next clock edge.
module tb_spi_cmd_handler;
    import spi_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mosi_data;
    logic       next_byte_ready;
    logic       new_transfer;
    logic [7:0] miso_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pop;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int pop_cnt = 0;

    logic [7:0]  fifo_mem [4];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic [7:0]  miso_exp [$];
    logic [14:0] wr_exp [$];
    logic [14:0] wr_e;

    spi_cmd_handler #(.STATUS_ID(4'h1)) dut (
        .clk             (clk),
        .reset           (reset),
        .mosi_data       (mosi_data),
        .next_byte_ready (next_byte_ready),
        .new_transfer    (new_transfer),
        .miso_data       (miso_data),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_we          (reg_we),
        .reg_rdata       (reg_rdata),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_pop          (rx_pop)
    );

    always #5 clk = ~clk;

    // Register file model: each register reads as its address + 0x10.
    assign reg_rdata = {1'b0, reg_addr} + 8'h10;
    assign rx_valid  = (fifo_wr != fifo_rd);
    assign rx_data   = fifo_mem[fifo_rd[1:0]];

    always @(posedge clk) begin
        if (rx_pop) fifo_rd <= fifo_rd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write scoreboard and strobe exclusivity monitor.
    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            chk("we_pop_excl", {31'd0, rx_pop}, 32'd0);
            if (wr_exp.size() == 0) begin
                chk("we_unexpected", {31'd0, reg_we}, 32'd0);
            end else begin
                wr_e = wr_exp.pop_front();
                chk("we_addr", {25'd0, reg_addr}, {25'd0, wr_e[14:8]});
                chk("we_data", {24'd0, reg_wdata}, {24'd0, wr_e[7:0]});
            end
        end
        if (rx_pop) pop_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_xfer();
        new_transfer = 1'b1;
        tick();
        new_transfer = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        mosi_data       = b;
        next_byte_ready = 1'b1;
        tick();
        next_byte_ready = 1'b0;
        mosi_data       = 8'h00;
        tick();
    endtask

    // Push the read value expected to be loaded after this byte, then compare.
    task automatic send_load(input string tag, input logic [7:0] b, input logic [7:0] exp);
        logic [7:0] e;
        miso_exp.push_back(exp);
        send(b);
        e = miso_exp.pop_front();
        chk(tag, {24'd0, miso_data}, {24'd0, e});
        idle(3);
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        chk(tag, 32'(dut.state), 32'(exp));
    endtask

    initial begin
        int we0;
        int pop0;
        reset           = 1'b1;
        mosi_data       = 8'h00;
        next_byte_ready = 1'b0;
        new_transfer    = 1'b0;
        idle(2);
        chk("rst_miso", {24'd0, miso_data}, 32'h00);
        chk("rst_addr", {25'd0, reg_addr}, 32'h00);
        chk("rst_we", {31'd0, reg_we}, 32'd0);
        chk("rst_pop", {31'd0, rx_pop}, 32'd0);
        chk_state("rst_state", ST_IDLE);
        reset = 1'b0;
        idle(2);

        // Bytes with no transfer open are ignored.
        send(8'h85);
        chk_state("idle_ignore_state", ST_IDLE);
        chk("idle_ignore_addr", {25'd0, reg_addr}, 32'h00);

        // Status byte with data pending, then stream reads draining two entries.
        fifo_mem[0] = 8'hA5;
        fifo_mem[1] = 8'h3C;
        fifo_wr     = 2;
        start_xfer();
        chk("status_vld", {24'd0, miso_data}, 32'h81);
        pop0 = pop_cnt;
        send_load("stream_0", 8'hFF, 8'hA5);
        send_load("stream_1", 8'h00, 8'h3C);
        send_load("stream_2", 8'h00, 8'h00);
        send_load("stream_3", 8'h00, 8'h00);
        chk("stream_addr", {25'd0, reg_addr}, 32'h7F);
        chk("stream_pops", pop_cnt - pop0, 32'd2);

        // Register read burst; data bytes of 0xFF must not disturb anything.
        start_xfer();
        chk("status_empty", {24'd0, miso_data}, 32'h01);
        send_load("rd_0", 8'h85, 8'h15);
        chk("rd_addr_0", {25'd0, reg_addr}, 32'h05);
        send_load("rd_1", 8'hFF, 8'h16);
        chk("rd_addr_1", {25'd0, reg_addr}, 32'h06);
        send_load("rd_2", 8'hFF, 8'h17);
        chk("rd_addr_2", {25'd0, reg_addr}, 32'h07);

        // Write burst wrapping from 0x7E to 0x00.
        we0 = we_cnt;
        start_xfer();
        send(8'h7E);
        chk("wr_miso_zero", {24'd0, miso_data}, 32'h00);
        chk_state("wr_state", ST_WRITE);
        wr_exp.push_back({7'h7E, 8'hAA});
        send(8'hAA);
        idle(2);
        chk("wr_wrap_addr", {25'd0, reg_addr}, 32'h00);
        wr_exp.push_back({7'h00, 8'hBB});
        send(8'hBB);
        idle(2);
        chk("wr_addr_after", {25'd0, reg_addr}, 32'h01);
        chk("wr_miso_hold", {24'd0, miso_data}, 32'h00);
        chk("wr_count", we_cnt - we0, 32'd2);

        // Abort a write after one data byte; next byte is a command again.
        we0 = we_cnt;
        start_xfer();
        send(8'h10);
        wr_exp.push_back({7'h10, 8'h11});
        send(8'h11);
        idle(2);
        start_xfer();
        chk_state("abort_state", ST_CMD);
        idle(2);
        chk("abort_we_count", we_cnt - we0, 32'd1);
        send_load("abort_redecode", 8'h85, 8'h15);
        chk_state("abort_read_state", ST_READ);

        // new_transfer coinciding with a byte: status kept, byte decoded as a write command.
        new_transfer    = 1'b1;
        next_byte_ready = 1'b1;
        mosi_data       = 8'h03;
        tick();
        new_transfer    = 1'b0;
        next_byte_ready = 1'b0;
        mosi_data       = 8'h00;
        tick();
        chk_state("coinc_state", ST_WRITE);
        chk("coinc_addr", {25'd0, reg_addr}, 32'h03);
        chk("coinc_miso", {24'd0, miso_data}, 32'h01);
        idle(2);

        // Asynchronous reset in the middle of a read burst.
        we0  = we_cnt;
        start_xfer();
        send_load("pre_rst_0", 8'h85, 8'h15);
        send_load("pre_rst_1", 8'hFF, 8'h16);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_miso", {24'd0, miso_data}, 32'h00);
        chk("arst_addr", {25'd0, reg_addr}, 32'h00);
        chk("arst_wdata", {24'd0, reg_wdata}, 32'h00);
        chk("arst_we", {31'd0, reg_we}, 32'd0);
        chk("arst_pop", {31'd0, rx_pop}, 32'd0);
        chk_state("arst_state", ST_IDLE);
        tick();
        reset = 1'b0;
        tick();
        send(8'h85);
        idle(2);
        chk_state("post_rst_state", ST_IDLE);
        chk("post_rst_addr", {25'd0, reg_addr}, 32'h00);
        chk("post_rst_miso", {24'd0, miso_data}, 32'h00);
        chk("post_rst_we", we_cnt - we0, 32'd0);

        chk("wr_queue_drained", wr_exp.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
